uart_rx_deser: RTL and testbench
================================

# uart_rx_deser

Receive-side UART deserializer that sits directly upstream of the Wishbone UART control block. It synchronizes the asynchronous serial line and recovers 8N1 frames by mid-bit sampling. It presents each received byte with a held interrupt, reports busy and framing-error status, and releases the byte when the control block pulses `rx_finish`. Its outputs connect one-to-one to the control block's `i_rx`, `i_irq`, `i_rx_busy` and `i_frame_err` inputs.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit period (50 MHz / 115200). Legal range is ≥ 4.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- `rx`  in  1  serial line, asynchronous to `clk`; idles high.
- `rx_finish`  in  1  single-cycle pulse from the control block that releases the current byte and error.
- `rx_data`  out  8  last correctly received byte; registered.
- `irq`  out  1  byte available; held until released.
- `rx_busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_err`  out  1  stop bit was sampled low; held until released.

## Operation
- **Synchronizer.** A 2-FF synchronizer on `rx`; both flops reset to 1. All FSM decisions use the second flop (`rxs`).
- **Constants.** `HALF = (CLKS_PER_BIT-1)/2`, integer division. The bit counter is `$clog2(CLKS_PER_BIT)` bits wide. The bit index is 3 bits.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE.** `rxs==0` → START, with the counter cleared.
  - **START.** The counter increments each cycle. At `count==HALF`, sample `rxs`:
    - 0 → DATA, with counter and index cleared.
    - 1 → IDLE. This is a glitch: no flag changes.
  - **DATA.** At `count==CLKS_PER_BIT-1`, sample `rxs`, shift it in LSB-first (shift right, insert at bit 7) and clear the counter.
    - Index 7 → STOP.
    - Otherwise the index increments.
  - **STOP.** At `count==CLKS_PER_BIT-1`, sample `rxs`:
    - 1 → load `rx_data` from the shift register, set `irq`, go to IDLE.
    - 0 → set `frame_err`, go to BREAK. `rx_data` is unchanged.
  - **BREAK.** Wait for `rxs==1`, then go to IDLE. The FSM stays in BREAK for at least one cycle.
- **rx_busy.** `rx_busy = (state != IDLE)`. Because BREAK lasts at least one cycle, `frame_err` is always high for at least one cycle while `rx_busy` is high. The control block relies on this to record the error.
- **Release.**
  - `rx_finish` clears both `irq` and `frame_err` on the next edge.
  - If a set and `rx_finish` occur in the same cycle, the set wins.
- **Overrun.** New frames are received while `irq` is still held. A completed good frame overwrites `rx_data`, and `irq` stays 1. Overrun detection belongs to the control block (it sees `rx_busy` while its buffer is full).
- **Error then good frame.** A good frame received while `frame_err` is held sets `irq` and leaves `frame_err` unchanged.
- **Reset.** Asserting `rst` at any time, including mid-frame, immediately forces:
  - state to IDLE, all counters and the shift register to 0, synchronizer flops to 1;
  - outputs `rx_data=0x00`, `irq=0`, `frame_err=0`, `rx_busy=0`.

## Timing
- **Start detection.** Let E be the first clock edge at which `rx` is sampled low. START is entered on edge E+2; call its first cycle S.
- **Sample points.**
  - Start bit: S+HALF.
  - Data bit k (k = 0..7): S+HALF+(k+1)·CLKS_PER_BIT.
  - Stop bit: S+HALF+9·CLKS_PER_BIT.
- **Output latency.** `irq`, `rx_data` (or `frame_err`) change on the edge that ends the stop-sample cycle. They are visible from cycle S+HALF+9·CLKS_PER_BIT+1.
- **Return to IDLE.** After a good stop bit, the FSM is in IDLE in the same cycle `irq` rises. It can detect the next start bit immediately.
- **Clock tolerance.** Mid-bit sampling tolerates ±4% total clock mismatch per frame.
- **Release latency.** `rx_finish` high in cycle C → `irq`/`frame_err` are 0 from cycle C+1.

## Test plan
All scenarios use `CLKS_PER_BIT=16` (HALF=7).
- **Good frame.** Send 0xA5 with stop=1 → `irq` rises at S+152; `rx_data=0xA5`; `frame_err=0`; `rx_busy` falls in the same cycle. `irq` holds for 50 cycles, then a `rx_finish` pulse → `irq=0` next cycle.
- **Glitch.** Drive `rx` low for 4 cycles → FSM returns to IDLE. `rx_busy` is high for exactly 8 cycles; `irq`, `frame_err` and `rx_data` are unchanged.
- **Framing error.** Send 0x3C with stop=0, then hold `rx` low for 40 cycles → `frame_err=1` and `rx_busy=1` together. `rx_busy` stays high until `rx` goes high. `rx_data` and `irq` are unchanged. A `rx_finish` pulse clears `frame_err`.
- **Back-to-back frames without release.** Send 0x11 then 0x22 with no `rx_finish` → `irq` stays 1; `rx_busy` is high during the second frame; `rx_data=0x22` at the second stop.
- **Release/set collision.** Pulse `rx_finish` in the exact cycle `irq` is being set by a new 0x7E → `irq=1` and `rx_data=0x7E`.
- **Reset mid-frame.** Assert `rst` mid-DATA of 0xFF → all outputs are 0 without waiting for a clock edge. After release, 0x5A is received correctly with `irq` at S+152.

Source files
------------

// File: rtl/uart_rx_deser_if.sv
// -----------------------------------------------------------------------------
// uart_rx_deser_if
//   Bundles the serial input and the byte/status handshake between the UART
//   receive deserializer and the Wishbone UART control block.
//
//   Signals:
//     rx         serial line into the deserializer (asynchronous, idles high)
//     rx_finish  single-cycle release pulse from the control block
//     rx_data    last correctly received byte
//     irq        byte available, held until released
//     rx_busy    deserializer is inside a frame (FSM not idle)
//     frame_err  stop bit sampled low, held until released
//
//   Modports:
//     master  the deserializer: consumes rx/rx_finish, drives the status
//     slave   the control block side (or a testbench standing in for it)
// -----------------------------------------------------------------------------
interface uart_rx_deser_if;
  logic       rx;
  logic       rx_finish;
  logic [7:0] rx_data;
  logic       irq;
  logic       rx_busy;
  logic       frame_err;

  modport master (
    input  rx,
    input  rx_finish,
    output rx_data,
    output irq,
    output rx_busy,
    output frame_err
  );

  modport slave (
    output rx,
    output rx_finish,
    input  rx_data,
    input  irq,
    input  rx_busy,
    input  frame_err
  );
endinterface

// File: rtl/uart_rx_deser.sv
// -----------------------------------------------------------------------------
// uart_rx_deser
//   Receive-side 8N1 UART deserializer. Synchronizes the serial line with two
//   flops, finds the start bit, samples each bit in the middle of its period
//   and presents the byte with a held interrupt. A low stop bit raises a held
//   framing error instead. The control block releases both flags with a
//   single-cycle rx_finish pulse.
//
//   Parameters:
//     CLKS_PER_BIT  clock cycles per bit period (>= 4)
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset
//     bus   uart_rx_deser_if.master (rx, rx_finish in; rx_data, irq,
//           rx_busy, frame_err out)
// -----------------------------------------------------------------------------
module uart_rx_deser #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic             clk,
  input  logic             rst,
  uart_rx_deser_if.master  bus
);

  localparam int HALF = (CLKS_PER_BIT - 1) / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);

  localparam logic [CW-1:0] C_HALF = CW'(HALF);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // Synchronizer
  logic          r_sync1;
  logic          r_rxs;

  // FSM and datapath state
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_irq;
  logic          r_err;

  // Control strobes from the next-state logic
  logic          w_cnt_clr;
  logic          w_idx_clr;
  logic          w_idx_inc;
  logic          w_shift;
  logic          w_set_irq;
  logic          w_set_err;
  logic          w_at_half;
  logic          w_at_last;

  assign w_at_half = (r_count == C_HALF);
  assign w_at_last = (r_count == C_LAST);

  // Both flops reset to 1 so that reset looks like an idle line and can never
  // fake a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value; with blocking ones the two stages would collapse into one.
      r_sync1 <= bus.rx;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    w_next    = r_state;
    w_cnt_clr = 1'b0;
    w_idx_clr = 1'b0;
    w_idx_inc = 1'b0;
    w_shift   = 1'b0;
    w_set_irq = 1'b0;
    w_set_err = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (!r_rxs) begin
          w_next    = S_START;
          w_cnt_clr = 1'b1;
        end
      end

      // Half a bit into the start bit: still low means a real start, high
      // means the low level was a glitch and nothing is reported.
      S_START: begin
        if (w_at_half) begin
          w_cnt_clr = 1'b1;
          if (!r_rxs) begin
            w_next    = S_DATA;
            w_idx_clr = 1'b1;
          end else begin
            w_next    = S_IDLE;
          end
        end
      end

      // From the start-bit midpoint, each full bit period lands in the middle
      // of the next bit.
      S_DATA: begin
        if (w_at_last) begin
          w_shift   = 1'b1;
          w_cnt_clr = 1'b1;
          if (r_idx == 3'd7) w_next    = S_STOP;
          else               w_idx_inc = 1'b1;
        end
      end

      S_STOP: begin
        if (w_at_last) begin
          w_cnt_clr = 1'b1;
          if (r_rxs) begin
            w_set_irq = 1'b1;
            w_next    = S_IDLE;
          end else begin
            w_set_err = 1'b1;
            w_next    = S_BREAK;
          end
        end
      end

      // Held here until the line returns high; the minimum one-cycle stay
      // guarantees frame_err is seen together with rx_busy.
      S_BREAK: begin
        if (r_rxs) w_next = S_IDLE;
      end

      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: the shift register and output byte are ordinary flops, not a
  // memory, so they take the async reset like everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_irq   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      if (w_cnt_clr)
        r_count <= '0;
      else if (r_state == S_START || r_state == S_DATA || r_state == S_STOP)
        r_count <= r_count + 1'b1;

      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 1'b1;

      // LSB arrives first: shift right, new bit in at the top.
      if (w_shift) r_shift <= {r_rxs, r_shift[7:1]};

      if (w_set_irq) r_data <= r_shift;

      // A set in the same cycle as a release wins.
      if (w_set_irq)          r_irq <= 1'b1;
      else if (bus.rx_finish) r_irq <= 1'b0;

      if (w_set_err)          r_err <= 1'b1;
      else if (bus.rx_finish) r_err <= 1'b0;
    end
  end

  assign bus.rx_data   = r_data;
  assign bus.irq       = r_irq;
  assign bus.frame_err = r_err;
  assign bus.rx_busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_deser
//   Self-checking bench for uart_rx_deser with CLKS_PER_BIT = 16 (HALF = 7).
//   Good frames come from a vector table; glitch, framing error, release/set
//   collision and mid-frame reset are written out as sequences.
// -----------------------------------------------------------------------------
module tb_uart_rx_deser;

  localparam int CPB       = 16;
  localparam int IRQ_CYCLE = 3 + 7 + 9 * CPB + 1;  // 155 edges after rx falls

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_deser_if u_if ();

  uart_rx_deser #(.CLKS_PER_BIT(CPB)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_pulse();
    u_if.rx_finish = 1'b1;
    tick();
    u_if.rx_finish = 1'b0;
  endtask

  // Drives one full 8N1 frame (10 bits of CPB cycles). Must be called #1 after
  // a rising edge. Edge numbers are counted from the call: flag_n is the first
  // edge where irq or frame_err rose, fall_n the first edge where rx_busy fell,
  // busy_mid is rx_busy in the middle of the data bits. rx_finish is held high
  // for the cycle following edge finish_at (-1 for never).
  task automatic send_frame(input logic [7:0] d, input bit stop, input int finish_at,
                            output int flag_n, output int fall_n, output bit busy_mid);
    logic [9:0] frm;
    logic       prev_flag;
    logic       prev_busy;
    frm      = {stop, d, 1'b0};
    flag_n   = 0;
    fall_n   = 0;
    busy_mid = 1'b0;
    for (int n = 0; n < 10 * CPB; n++) begin
      u_if.rx        = frm[n / CPB];
      u_if.rx_finish = (n == finish_at);
      prev_flag      = u_if.irq | u_if.frame_err;
      prev_busy      = u_if.rx_busy;
      tick();
      if (!prev_flag && (u_if.irq | u_if.frame_err) && flag_n == 0) flag_n = n + 1;
      if (prev_busy && !u_if.rx_busy && fall_n == 0) fall_n = n + 1;
      if (n + 1 == 5 * CPB) busy_mid = u_if.rx_busy;
    end
    u_if.rx_finish = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    int         hold;      // cycles to watch irq held before releasing
    bit         release_f; // pulse rx_finish after the frame
    bit         exp_rise;  // irq was low before, so it must rise at IRQ_CYCLE
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int  flag_n, fall_n, cnt;
    bit  busy_mid, held;

    u_if.rx        = 1'b1;
    u_if.rx_finish = 1'b0;

    vecs[0] = '{d: 8'hA5, hold: 50, release_f: 1'b1, exp_rise: 1'b1, exp_data: 8'hA5};
    vecs[1] = '{d: 8'h11, hold: 0,  release_f: 1'b0, exp_rise: 1'b1, exp_data: 8'h11};
    vecs[2] = '{d: 8'h22, hold: 0,  release_f: 1'b1, exp_rise: 1'b0, exp_data: 8'h22};

    // Reset state
    #1;
    check("reset rx_data",   u_if.rx_data,   8'h00);
    check("reset irq",       u_if.irq,       1'b0);
    check("reset frame_err", u_if.frame_err, 1'b0);
    check("reset rx_busy",   u_if.rx_busy,   1'b0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (4) tick();

    // Good frames, including back-to-back without release
    foreach (vecs[i]) begin
      send_frame(vecs[i].d, 1'b1, -1, flag_n, fall_n, busy_mid);
      check($sformatf("v%0d busy mid-frame", i), busy_mid, 1'b1);
      check($sformatf("v%0d irq rise edge", i), flag_n, vecs[i].exp_rise ? IRQ_CYCLE : 0);
      check($sformatf("v%0d busy fall edge", i), fall_n, IRQ_CYCLE);
      check($sformatf("v%0d irq", i), u_if.irq, 1'b1);
      check($sformatf("v%0d frame_err", i), u_if.frame_err, 1'b0);
      check($sformatf("v%0d rx_data", i), u_if.rx_data, vecs[i].exp_data);
      if (vecs[i].hold > 0) begin
        held = 1'b1;
        repeat (vecs[i].hold) begin
          tick();
          held &= u_if.irq;
        end
        check($sformatf("v%0d irq held", i), held, 1'b1);
      end
      if (vecs[i].release_f) begin
        release_pulse();
        check($sformatf("v%0d irq released", i), u_if.irq, 1'b0);
      end
      repeat (3) tick();
    end

    // Glitch: 4 low cycles -> exactly 8 busy cycles, nothing else changes
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      u_if.rx = (i >= 4);
      tick();
      if (u_if.rx_busy) cnt++;
    end
    check("glitch busy cycles", cnt, 8);
    check("glitch irq",         u_if.irq,       1'b0);
    check("glitch frame_err",   u_if.frame_err, 1'b0);
    check("glitch rx_data",     u_if.rx_data,   8'h22);

    // Framing error: 0x3C with a low stop bit, line held low 40 more cycles
    send_frame(8'h3C, 1'b0, -1, flag_n, fall_n, busy_mid);
    check("ferr flag edge", flag_n, IRQ_CYCLE);
    check("ferr busy never fell", fall_n, 0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (u_if.frame_err && u_if.rx_busy) cnt++;
    end
    check("ferr err+busy held", cnt, 40);
    check("ferr irq",     u_if.irq,     1'b0);
    check("ferr rx_data", u_if.rx_data, 8'h22);
    u_if.rx = 1'b1;
    cnt = 0;
    while (u_if.rx_busy && cnt < 10) begin
      tick();
      cnt++;
    end
    check("ferr busy drop latency", cnt, 3);
    check("ferr err still held", u_if.frame_err, 1'b1);
    release_pulse();
    check("ferr released", u_if.frame_err, 1'b0);
    repeat (3) tick();

    // Release/set collision: irq held from 0x11, rx_finish in the set cycle
    send_frame(8'h11, 1'b1, -1, flag_n, fall_n, busy_mid);
    repeat (3) tick();
    send_frame(8'h7E, 1'b1, IRQ_CYCLE - 1, flag_n, fall_n, busy_mid);
    check("collision irq",     u_if.irq,     1'b1);
    check("collision rx_data", u_if.rx_data, 8'h7E);
    repeat (3) tick();

    // Reset mid-DATA of 0xFF: outputs clear without a clock edge
    u_if.rx = 1'b0;
    repeat (CPB) tick();
    u_if.rx = 1'b1;
    repeat (40) tick();
    check("pre-reset busy", u_if.rx_busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst rx_data",   u_if.rx_data,   8'h00);
    check("async rst irq",       u_if.irq,       1'b0);
    check("async rst frame_err", u_if.frame_err, 1'b0);
    check("async rst rx_busy",   u_if.rx_busy,   1'b0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    send_frame(8'h5A, 1'b1, -1, flag_n, fall_n, busy_mid);
    check("post-reset irq edge", flag_n,       IRQ_CYCLE);
    check("post-reset rx_data",  u_if.rx_data, 8'h5A);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
